// File: rtl/lcd_arbiter.sv
// Two-requester round-robin arbiter in front of a single LCD encoder command port.
// Latches the winner's command at grant, waits for the encoder to accept it (with timeout) and to finish.
module lcd_arbiter #(
    parameter int TIMEOUT_CYCLES    = 1023,
    parameter int TIMEOUT_BIT_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_busy,
    input  logic        data_busy,
    input  logic [1:0]  req,
    input  logic [15:0] req_data,
    input  logic [11:0] req_addr_y,
    input  logic [5:0]  req_addr_x,
    input  logic [3:0]  req_action,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        error,
    output logic [7:0]  enc_data,
    output logic [5:0]  enc_addr_y,
    output logic [2:0]  enc_addr_x,
    output logic [1:0]  enc_action
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_FINISH, COMPLETE} state_t;

    localparam logic [TIMEOUT_BIT_WIDTH-1:0] TMO_MAX = TIMEOUT_BIT_WIDTH'(TIMEOUT_CYCLES);

    state_t                       state_q, state_d;
    logic [1:0]                   grant_q, grant_d;
    logic                         last_q, last_d;
    logic [7:0]                   data_q, data_d;
    logic [5:0]                   addr_y_q, addr_y_d;
    logic [2:0]                   addr_x_q, addr_x_d;
    logic [1:0]                   action_q, action_d;
    logic [TIMEOUT_BIT_WIDTH-1:0] tmo_q, tmo_d;
    logic                         err_q, err_d;
    logic                         win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 1'b1;
            data_q   <= '0;
            addr_y_q <= '0;
            addr_x_q <= '0;
            action_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            data_q   <= data_d;
            addr_y_q <= addr_y_d;
            addr_x_q <= addr_x_d;
            action_q <= action_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        data_d   = data_q;
        addr_y_d = addr_y_q;
        addr_x_d = addr_x_q;
        action_d = action_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        // With both requesting, the one not served last wins; otherwise the lone requester.
        win      = (req == 2'b11) ? ~last_q : req[1];
        unique case (state_q)
            IDLE: begin
                if (!instr_busy && req != 2'b00) begin
                    grant_d  = win ? 2'b10 : 2'b01;
                    last_d   = win;
                    data_d   = win ? req_data[15:8]   : req_data[7:0];
                    addr_y_d = win ? req_addr_y[11:6] : req_addr_y[5:0];
                    addr_x_d = win ? req_addr_x[5:3]  : req_addr_x[2:0];
                    action_d = win ? req_action[3:2]  : req_action[1:0];
                    err_d    = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = (action_q == 2'b00) ? COMPLETE : WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (data_busy) begin
                    action_d = 2'b00;
                    state_d  = WAIT_FINISH;
                end else if (tmo_q == TMO_MAX) begin
                    action_d = 2'b00;
                    err_d    = 1'b1;
                    state_d  = COMPLETE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_FINISH: begin
                if (!data_busy) state_d = COMPLETE;
            end
            COMPLETE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = grant_q;
    assign done       = (state_q == COMPLETE) ? grant_q : 2'b00;
    assign error      = (state_q == COMPLETE) && err_q;
    assign enc_data   = data_q;
    assign enc_addr_y = addr_y_q;
    assign enc_addr_x = addr_x_q;
    assign enc_action = action_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter: expected done/error pairs are queued at grant and
// consumed by a monitor whenever the DUT pulses done.
module tb_lcd_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_busy = 1'b0;
    logic        data_busy = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [11:0] req_addr_y = '0;
    logic [5:0]  req_addr_x = '0;
    logic [3:0]  req_action = '0;
    logic [1:0]  grant, done;
    logic        error;
    logic [7:0]  enc_data;
    logic [5:0]  enc_addr_y;
    logic [2:0]  enc_addr_x;
    logic [1:0]  enc_action;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q[$];   // {error, done}

    lcd_arbiter #(.TIMEOUT_CYCLES(15), .TIMEOUT_BIT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .instr_busy(instr_busy), .data_busy(data_busy),
        .req(req), .req_data(req_data), .req_addr_y(req_addr_y), .req_addr_x(req_addr_x),
        .req_action(req_action), .grant(grant), .done(done), .error(error),
        .enc_data(enc_data), .enc_addr_y(enc_addr_y), .enc_addr_x(enc_addr_x),
        .enc_action(enc_action)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_done observed=%0h expected=none", done);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                assert ({error, done} === e) else begin
                    failures++;
                    $error("FAIL done_error observed=%0h expected=%0h", {error, done}, e);
                end
            end
        end
    end

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n = 0;
        while (grant == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check(tag, grant, exp);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        if (done == 2'b00) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_action", enc_action, 0);
        check("rst_data", enc_data, 0);
        check("rst_addr_y", enc_addr_y, 0);
        check("rst_addr_x", enc_addr_x, 0);
        reset = 1'b0;
        tick();

        // Single request, encoder accepts after a few cycles
        req = 2'b01; req_action = 4'b0001; req_data = 16'h00A5;
        req_addr_y = 12'd10; req_addr_x = 6'd2;
        exp_q.push_back(3'b0_01);
        tick();
        check("single_grant", grant, 2'b01);
        check("single_cmd", {enc_data, enc_addr_y, enc_addr_x, enc_action}, {8'hA5, 6'd10, 3'd2, 2'b01});
        req = 2'b00; req_data = 16'h0000; req_action = 4'b0000;
        tick(); tick();
        check("single_hold", {enc_data, enc_action}, {8'hA5, 2'b01});
        data_busy = 1'b1;
        tick();
        check("single_accepted", {enc_data, enc_action}, {8'hA5, 2'b00});
        repeat (4) tick();
        data_busy = 1'b0;
        wait_done("single_done", n);
        tick();
        check("single_done_1cyc", {grant, done, error}, 5'b0);

        // Contention: alternating grants from reset
        do_reset();
        req = 2'b11; req_action = 4'b0101; req_data = 16'h2211;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_q.push_back({1'b0, g});
            wait_grant($sformatf("rr_grant%0d", k), g);
            check($sformatf("rr_data%0d", k), enc_data, g[0] ? 8'h11 : 8'h22);
            data_busy = 1'b1;
            tick(); tick();
            data_busy = 1'b0;
            wait_done($sformatf("rr_done%0d", k), n);
            tick();
        end
        req = 2'b00;
        tick();

        // Timeout with encoder never accepting
        req = 2'b01; req_action = 4'b0010;
        exp_q.push_back(3'b1_01);
        wait_grant("tmo_grant", 2'b01);
        req = 2'b00;
        wait_done("tmo_done", n);
        check("tmo_latency_ok", (n == 16 || n == 17), 1);
        check("tmo_action_cleared", enc_action, 2'b00);
        tick();
        check("tmo_error_1cyc", {error, grant}, 3'b0);

        // instr_busy holds off, then a NONE action completes without the encoder
        instr_busy = 1'b1; req = 2'b10; req_action = 4'b0000;
        repeat (3) tick();
        check("ibusy_hold", grant, 2'b00);
        instr_busy = 1'b0;
        exp_q.push_back(3'b0_10);
        tick();
        check("ibusy_release_grant", grant, 2'b10);
        check("none_action_issue", enc_action, 2'b00);
        req = 2'b00; instr_busy = 1'b1;
        tick();
        check("none_done", done, 2'b10);
        check("none_action_complete", enc_action, 2'b00);
        instr_busy = 1'b0;
        tick();

        // Reset while waiting for the encoder to finish
        req = 2'b01; req_action = 4'b0011; req_data = 16'h003C;
        wait_grant("abort_grant", 2'b01);
        req = 2'b00; data_busy = 1'b1;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("abort_grant_cleared", grant, 2'b00);
        check("abort_enc_cleared", {enc_data, enc_action}, 10'b0);
        tick();
        reset = 1'b0; data_busy = 1'b0;
        req = 2'b11; req_action = 4'b0101;
        exp_q.push_back(3'b0_01);
        wait_grant("post_reset_grant", 2'b01);
        req = 2'b00; data_busy = 1'b1;
        tick(); tick();
        data_busy = 1'b0;
        wait_done("post_reset_done", n);
        repeat (3) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
